seq_mult: RTL

Parametrised iterative radix-2 shift-add multiplier for the DDS datapath, e.g. amplitude scaling of phase-to-amplitude output.
- Replaces the fixed-width free-running multiplier with a start/busy/done handshake.
- Supports run-time selectable signed (two's complement) or unsigned operands.
- Uses one adder of width M instead of a full array; trades latency (M+1 cycles) for area.

---
 rtl/seq_mult_if.sv | 19 +
 rtl/seq_mult.sv | 99 +++++++++
 2 files changed

// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/result bundle for the iterative multiplier.
//   start  - request a multiplication (master -> slave)
//   sgn    - 1 = operands are two's complement, 0 = unsigned
//   a, b   - M-bit multiplicand and multiplier
//   busy   - multiplication in progress (slave -> master)
//   done   - one-cycle pulse, mult freshly updated
//   mult   - 2M-bit product, held until the next done
interface seq_mult_if #(parameter int M = 8);
    logic           start;
    logic           sgn;
    logic [M-1:0]   a;
    logic [M-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*M-1:0] mult;

    modport master (output start, sgn, a, b, input busy, done, mult);
    modport slave  (input start, sgn, a, b, output busy, done, mult);
endinterface

// File: rtl/seq_mult.sv
// seq_mult: radix-2 shift-add multiplier with start/busy/done handshake.
// Operands are reduced to magnitudes at start, multiplied with a single
// M-bit adder over M cycles, and the sign is applied on the final cycle.
// Latency is M+1 edges from the start edge to the done edge; a new start
// may be accepted in the done cycle for back-to-back operation.
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - seq_mult_if slave modport (start, sgn, a, b, busy, done, mult)
module seq_mult #(
    parameter int M     = 8,
    parameter int CNT_W = $clog2(M) + 1
) (
    input  logic       clk,
    input  logic       rst,
    seq_mult_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state;
    logic [M-1:0]   mcand;
    logic [M-1:0]   acc_hi;
    logic [M-1:0]   acc_lo;
    logic [CNT_W-1:0] cnt;
    logic           neg;
    logic           busy_q;
    logic           done_q;
    logic [2*M-1:0] mult_q;

    logic [M-1:0]   mag_a;
    logic [M-1:0]   mag_b;
    logic           res_neg;
    logic [M:0]     sum;
    logic [2*M-1:0] prod;
    logic [2*M-1:0] prod_signed;

    // Magnitudes fit in M unsigned bits even for the most negative value.
    // The partial sum keeps the adder carry so the shift loses nothing.
    // A zero product negates to zero, so no negative zero can appear.
    always_comb begin
        mag_a       = (bus.sgn && bus.a[M-1]) ? -bus.a : bus.a;
        mag_b       = (bus.sgn && bus.b[M-1]) ? -bus.b : bus.b;
        res_neg     = bus.sgn & (bus.a[M-1] ^ bus.b[M-1]);
        sum         = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        prod        = {acc_hi, acc_lo};
        prod_signed = neg ? -prod : prod;
    end

    // acc_lo starts as the multiplier and fills with product bits as it
    // shifts right; the counter reaching M marks all partial products added.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mult_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (bus.start) begin
                        mcand  <= mag_a;
                        acc_lo <= mag_b;
                        acc_hi <= '0;
                        neg    <= res_neg;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(M)) begin
                        mult_q <= prod_signed;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= FIN;
                    end else begin
                        acc_hi <= sum[M:1];
                        acc_lo <= {sum[0], acc_lo[M-1:1]};
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.mult = mult_q;

endmodule
